// File: rtl/core_pkg.sv
// Shared constants for the multi-cycle RV32 subset sequencer.
package core_pkg;

  // Opcodes of the supported instruction classes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Sequencer states; the numeric values are visible on state_o
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'b01;
  localparam logic [1:0] CAUSE_FETCH_TMO = 2'b10;
  localparam logic [1:0] CAUSE_DATA_TMO  = 2'b11;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Only BEQ is implemented among branches, so other func3 values are illegal.
  function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE: is_legal = 1'b1;
      OPC_BRANCH:                             is_legal = (f3 == 3'b000);
      default:                                is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bus_wdog.sv
// Bus wait watchdog: counts cycles without ack and flags expiry once
// BUS_TIMEOUT wait cycles have elapsed. BUS_TIMEOUT = 0 never expires.
// The counter saturates at the limit, so the expiry cycle itself still
// lets a coincident ack win in the sequencer.
module bus_wdog #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(BUS_TIMEOUT);

  logic [W-1:0] cnt;

  assign expired = (BUS_TIMEOUT != 0) && (cnt == LIMIT);

  // Wait-cycle counter, cleared on every state change of the sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns PC, IR, MDR and instret, steps
// each instruction through FETCH/DECODE/EXEC/MEM/WB and traps on illegal
// opcodes or bus timeouts.
//
// Bus handshake: a request (imem_req_o / dmem_req_o) is a decode of the
// state register and stays high for every cycle spent in FETCH / MEM. A
// transfer completes on the first rising edge where request and ack are
// both high; that includes the very first cycle of the state. Acks while
// the matching request is low are ignored.
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        run_i,
  input  logic        trap_clr_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  func3_i,
  input  logic        reg_write_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  input  logic        branch_i,
  input  logic [31:0] imm_i,
  input  logic        alu_zero_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mdr_o,
  output logic        rf_we_o,
  output logic        wb_sel_o,
  output logic        retire_o,
  output logic [31:0] instret_o,
  output logic [2:0]  state_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, mdr_q, instret_q;
  logic [1:0]  cause_q, cause_d;
  logic        ir_ld, mdr_ld, retire;
  logic        wdog_clr, wdog_en, wdog_expired;

  // One watchdog serves both FETCH and MEM; it restarts on every state change
  assign wdog_clr = (state_d != state_q);
  assign wdog_en  = ((state_q == ST_FETCH) && !imem_ack_i) ||
                    ((state_q == ST_MEM)   && !dmem_ack_i);

  bus_wdog #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_wdog (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  // Next-state, PC update and load enables
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    ir_ld   = 1'b0;
    mdr_ld  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack_i) begin
          ir_ld   = 1'b1;
          state_d = ST_DECODE;
        end else if (wdog_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_FETCH_TMO;
        end
      end
      ST_DECODE: begin
        if (is_legal(opcode_i, func3_i)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (branch_i) begin
          pc_d   = alu_zero_i ? (pc_q + imm_i) : (pc_q + 32'd4);
          retire = 1'b1;
        end else if (mem_write_i || mem_to_reg_i) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack_i) begin
          if (mem_write_i) begin
            pc_d   = pc_q + 32'd4;
            retire = 1'b1;
          end else begin
            mdr_ld  = 1'b1;
            state_d = ST_WB;
          end
        end else if (wdog_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DATA_TMO;
        end
      end
      ST_WB: begin
        pc_d   = pc_q + 32'd4;
        retire = 1'b1;
      end
      ST_TRAP: begin
        if (trap_clr_i) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // run_i is only consulted at the instruction boundary
    if (retire) state_d = run_i ? ST_FETCH : ST_IDLE;
  end

  // State and architectural registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      pc_q      <= PC_RESET;
      ir_q      <= NOP_INSN;
      mdr_q     <= '0;
      instret_q <= '0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      if (ir_ld)  ir_q      <= imem_rdata_i;
      if (mdr_ld) mdr_q     <= dmem_rdata_i;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign imem_req_o   = (state_q == ST_FETCH);
  assign dmem_req_o   = (state_q == ST_MEM);
  assign dmem_we_o    = (state_q == ST_MEM) && mem_write_i;
  assign rf_we_o      = (state_q == ST_WB) && reg_write_i;
  assign wb_sel_o     = (state_q == ST_WB) && mem_to_reg_i;
  assign retire_o     = retire;
  assign trap_o       = (state_q == ST_TRAP);
  assign trap_cause_o = cause_q;
  assign state_o      = state_q;
  assign pc_o         = pc_q;
  assign ir_o         = ir_q;
  assign mdr_o        = mdr_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl; the bench plays decoder, ALU flag and
// both memories. DUT built with BUS_TIMEOUT = 4.
module tb_core_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        run_i, trap_clr_i;
  logic        imem_req_o, imem_ack_i;
  logic [31:0] imem_rdata_i, ir_o, pc_o;
  logic [6:0]  opcode_i;
  logic [2:0]  func3_i;
  logic        reg_write_i, mem_write_i, mem_to_reg_i, branch_i;
  logic [31:0] imm_i;
  logic        alu_zero_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] dmem_rdata_i, mdr_o;
  logic        rf_we_o, wb_sel_o, retire_o;
  logic [31:0] instret_o;
  logic [2:0]  state_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  int   cyc;
  logic saw_we, saw_dwe, saw_sel;

  // Clock
  always #5 clk_i = ~clk_i;

  core_seq_ctrl #(.PC_RESET(32'h0000_0000), .BUS_TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .run_i        (run_i),
    .trap_clr_i   (trap_clr_i),
    .imem_req_o   (imem_req_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .ir_o         (ir_o),
    .pc_o         (pc_o),
    .opcode_i     (opcode_i),
    .func3_i      (func3_i),
    .reg_write_i  (reg_write_i),
    .mem_write_i  (mem_write_i),
    .mem_to_reg_i (mem_to_reg_i),
    .branch_i     (branch_i),
    .imm_i        (imm_i),
    .alu_zero_i   (alu_zero_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .mdr_o        (mdr_o),
    .rf_we_o      (rf_we_o),
    .wb_sel_o     (wb_sel_o),
    .retire_o     (retire_o),
    .instret_o    (instret_o),
    .state_o      (state_o),
    .trap_o       (trap_o),
    .trap_cause_o (trap_cause_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_dec(input logic [6:0] opc, input logic [2:0] f3, input logic rw,
                         input logic mw, input logic mr, input logic br, input logic [31:0] imm);
    opcode_i = opc; func3_i = f3; reg_write_i = rw; mem_write_i = mw;
    mem_to_reg_i = mr; branch_i = br; imm_i = imm;
  endtask

  // Starts one instruction from IDLE with run_i dropped after the fetch
  // begins, so the sequencer returns to IDLE at retire. The memories ack
  // after iw / dw wait cycles. Stops at retire, on trap, or after 40 cycles.
  task automatic issue(input logic [31:0] word, input logic [6:0] opc, input logic [2:0] f3,
                       input logic rw, input logic mw, input logic mr, input logic br,
                       input logic [31:0] imm, input logic zero, input int iw, input int dw,
                       input logic [31:0] rdata, output int cycles,
                       output logic s_we, output logic s_dwe, output logic s_sel);
    int   icnt, dcnt;
    logic done;
    set_dec(opc, f3, rw, mw, mr, br, imm);
    imem_rdata_i = word; alu_zero_i = zero; dmem_rdata_i = rdata;
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0; run_i = 1'b1;
    cycles = 0; icnt = 0; dcnt = 0; done = 1'b0;
    s_we = 1'b0; s_dwe = 1'b0; s_sel = 1'b0;
    tick();
    run_i = 1'b0;
    while (!done && cycles < 40 && !trap_o) begin
      cycles++;
      imem_ack_i = imem_req_o && (icnt >= iw);
      dmem_ack_i = dmem_req_o && (dcnt >= dw);
      #1;
      if (rf_we_o)   s_we  = 1'b1;
      if (dmem_we_o) s_dwe = 1'b1;
      if (wb_sel_o)  s_sel = 1'b1;
      if (retire_o)  done  = 1'b1;
      if (imem_req_o) icnt++;
      if (dmem_req_o) dcnt++;
      tick();
    end
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
  endtask

  task automatic clear_trap();
    trap_clr_i = 1'b1;
    tick();
    check("clr_state", 32'(state_o), 32'd0);
    check("clr_cause", 32'(trap_cause_o), 32'd0);
    trap_clr_i = 1'b0;
  endtask

  initial begin
    // Reset
    rst_n_i = 1'b1; run_i = 1'b0; trap_clr_i = 1'b0;
    imem_ack_i = 1'b0; imem_rdata_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    alu_zero_i = 1'b0;
    set_dec(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_state",   32'(state_o), 32'd0);
    check("rst_pc",      pc_o, 32'h0);
    check("rst_ir",      ir_o, 32'h0000_0013);
    check("rst_mdr",     mdr_o, 32'h0);
    check("rst_instret", instret_o, 32'h0);
    check("rst_strobes", {24'd0, imem_req_o, dmem_req_o, dmem_we_o, rf_we_o,
                          retire_o, trap_o, trap_cause_o}, 32'h0);
    tick();

    exp_q.push_back(32'd4);  exp_q.push_back(32'd8);  exp_q.push_back(32'd12);
    exp_q.push_back(32'd28); exp_q.push_back(32'd32); exp_q.push_back(32'd36);

    // ADDI x1,x0,5 stepped cycle by cycle
    set_dec(7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5);
    imem_rdata_i = 32'h0050_0093; imem_ack_i = 1'b1; run_i = 1'b1; rst_n_i = 1'b1;
    tick();
    check("addi_c1_state", 32'(state_o), 32'd1);
    check("addi_c1_ireq",  32'(imem_req_o), 32'd1);
    tick();
    check("addi_c2_state", 32'(state_o), 32'd2);
    check("addi_c2_ir",    ir_o, 32'h0050_0093);
    check("addi_c2_ireq",  32'(imem_req_o), 32'd0);
    tick();
    check("addi_c3_state", 32'(state_o), 32'd3);
    check("addi_c3_rfwe",  32'(rf_we_o), 32'd0);
    tick();
    run_i = 1'b0;
    #1;
    check("addi_c4_state",  32'(state_o), 32'd5);
    check("addi_c4_rfwe",   32'(rf_we_o), 32'd1);
    check("addi_c4_retire", 32'(retire_o), 32'd1);
    check("addi_c4_wbsel",  32'(wb_sel_o), 32'd0);
    tick();
    imem_ack_i = 1'b0;
    check("addi_idle",    32'(state_o), 32'd0);
    check("addi_pc",      pc_o, exp_q.pop_front());
    check("addi_instret", instret_o, 32'd1);
    check("addi_rfwe_off", 32'(rf_we_o), 32'd0);

    // ADD x3,x1,x2
    issue(32'h0020_81B3, 7'b0110011, 3'd0, 1, 0, 0, 0, 32'd0, 0, 0, 0, 32'd0,
          cyc, saw_we, saw_dwe, saw_sel);
    check("add_cycles", 32'(cyc), 32'd4);
    check("add_rfwe",   32'(saw_we), 32'd1);
    check("add_pc",     pc_o, exp_q.pop_front());

    // BEQ x0,x0,+16 not taken at pc=8
    issue(32'h0000_0863, 7'b1100011, 3'd0, 0, 0, 0, 1, 32'd16, 0, 0, 0, 32'd0,
          cyc, saw_we, saw_dwe, saw_sel);
    check("beq_nt_cycles", 32'(cyc), 32'd3);
    check("beq_nt_pc",     pc_o, exp_q.pop_front());

    // BEQ taken at pc=12
    issue(32'h0000_0863, 7'b1100011, 3'd0, 0, 0, 0, 1, 32'd16, 1, 0, 0, 32'd0,
          cyc, saw_we, saw_dwe, saw_sel);
    check("beq_t_cycles", 32'(cyc), 32'd3);
    check("beq_t_rfwe",   32'(saw_we), 32'd0);
    check("beq_t_pc",     pc_o, exp_q.pop_front());
    check("beq_t_idle",   32'(state_o), 32'd0);

    // LW with three data wait cycles
    issue(32'h0000_2083, 7'b0000011, 3'd2, 1, 0, 1, 0, 32'd0, 0, 0, 3, 32'hDEAD_BEEF,
          cyc, saw_we, saw_dwe, saw_sel);
    check("lw_cycles", 32'(cyc), 32'd8);
    check("lw_mdr",    mdr_o, 32'hDEAD_BEEF);
    check("lw_wbsel",  32'(saw_sel), 32'd1);
    check("lw_rfwe",   32'(saw_we), 32'd1);
    check("lw_pc",     pc_o, exp_q.pop_front());

    // SW
    issue(32'h0010_2023, 7'b0100011, 3'd2, 0, 1, 0, 0, 32'd0, 0, 0, 0, 32'd0,
          cyc, saw_we, saw_dwe, saw_sel);
    check("sw_cycles",  32'(cyc), 32'd4);
    check("sw_dwe",     32'(saw_dwe), 32'd1);
    check("sw_rfwe",    32'(saw_we), 32'd0);
    check("sw_pc",      pc_o, exp_q.pop_front());
    check("sw_instret", instret_o, 32'd6);

    // Illegal opcode
    issue(32'hFFFF_FFFF, 7'b1111111, 3'd0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 32'd0,
          cyc, saw_we, saw_dwe, saw_sel);
    check("ill_cycles",  32'(cyc), 32'd2);
    check("ill_state",   32'(state_o), 32'd6);
    check("ill_trap",    32'(trap_o), 32'd1);
    check("ill_cause",   32'(trap_cause_o), 32'd1);
    check("ill_pc",      pc_o, 32'd36);
    check("ill_ir",      ir_o, 32'hFFFF_FFFF);
    check("ill_instret", instret_o, 32'd6);
    clear_trap();

    // Branch opcode with func3 other than BEQ
    issue(32'h0000_1863, 7'b1100011, 3'd1, 0, 0, 0, 1, 32'd16, 1, 0, 0, 32'd0,
          cyc, saw_we, saw_dwe, saw_sel);
    check("bne_cause", 32'(trap_cause_o), 32'd1);
    check("bne_pc",    pc_o, 32'd36);
    clear_trap();

    // Fetch never acked: 5 request cycles (0..4 waits) then TRAP
    issue(32'h0050_0093, 7'b0010011, 3'd0, 1, 0, 0, 0, 32'd5, 0, 100, 0, 32'd0,
          cyc, saw_we, saw_dwe, saw_sel);
    check("ftmo_cycles", 32'(cyc), 32'd5);
    check("ftmo_cause",  32'(trap_cause_o), 32'd2);
    check("ftmo_pc",     pc_o, 32'd36);
    check("ftmo_ireq",   32'(imem_req_o), 32'd0);
    clear_trap();

    // Fetch ack on the expiry cycle wins
    issue(32'h0050_0093, 7'b0010011, 3'd0, 1, 0, 0, 0, 32'd5, 0, 4, 0, 32'd0,
          cyc, saw_we, saw_dwe, saw_sel);
    check("fedge_cycles",  32'(cyc), 32'd8);
    check("fedge_trap",    32'(trap_o), 32'd0);
    check("fedge_pc",      pc_o, 32'd40);
    check("fedge_instret", instret_o, 32'd7);

    // Data never acked
    issue(32'h0000_2083, 7'b0000011, 3'd2, 1, 0, 1, 0, 32'd0, 0, 0, 100, 32'h1234_5678,
          cyc, saw_we, saw_dwe, saw_sel);
    check("dtmo_cycles", 32'(cyc), 32'd8);
    check("dtmo_cause",  32'(trap_cause_o), 32'd3);
    check("dtmo_mdr",    mdr_o, 32'hDEAD_BEEF);
    clear_trap();

    // Reset asserted while waiting in MEM
    set_dec(7'b0000011, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    imem_rdata_i = 32'h0000_2083; imem_ack_i = 1'b1; dmem_ack_i = 1'b0; run_i = 1'b1;
    tick(); tick(); tick(); tick();
    check("rmem_state", 32'(state_o), 32'd4);
    check("rmem_dreq",  32'(dmem_req_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check("rmem_dreq_drop", 32'(dmem_req_o), 32'd0);
    check("rmem_state0",    32'(state_o), 32'd0);
    check("rmem_pc",        pc_o, 32'h0);
    check("rmem_ir",        ir_o, 32'h0000_0013);
    check("rmem_mdr",       mdr_o, 32'h0);
    check("rmem_instret",   instret_o, 32'h0);
    imem_ack_i = 1'b0; run_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
